// File: rtl/gbuf_loader.sv
// Byte-stream to word packer that fills one global buffer (A or B) row by row.
// Four bytes per word, little-endian; pulses done once the requested rows are written.
module gbuf_loader #(
    parameter int WORD_SIZE = 32,
    parameter int IDX_W     = 5,
    parameter int DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IDX_W:0]       num_words,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 wr_en,
    output logic [IDX_W-1:0]     index,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err_short
);

    localparam int BPW  = WORD_SIZE / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W:0]  LP_DEPTH     = (IDX_W + 1)'(DEPTH);
    localparam logic [BC_W-1:0] LP_LAST_BYTE = BC_W'(BPW - 1);
    localparam logic [IDX_W:0]  LP_ONE_W     = (IDX_W + 1)'(1);
    localparam logic [BC_W-1:0] LP_ONE_B     = BC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IDX_W:0]       r_count;
    logic [IDX_W:0]       r_word_cnt;
    logic [BC_W-1:0]      r_byte_cnt;
    logic [WORD_SIZE-1:0] r_pack;
    logic                 r_short;

    logic [IDX_W:0]       w_count_in;
    logic                 w_hs;
    logic                 w_last_byte;
    logic                 w_final_word;

    // Handshake qualification and the clamped load length.
    always_comb begin
        w_count_in   = (num_words > LP_DEPTH) ? LP_DEPTH : num_words;
        w_hs         = (r_state == ST_FILL) && s_valid;
        w_last_byte  = (r_byte_cnt == LP_LAST_BYTE);
        w_final_word = ((r_word_cnt + LP_ONE_W) == r_count);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_count_in == '0) ? ST_DONE : ST_FILL;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_hs && (w_last_byte || s_last)) begin
                    w_next = ST_WRITE;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (w_final_word || r_short) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters, pack register and early-termination flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_pack     <= '0;
            r_short    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count    <= w_count_in;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_pack     <= '0;
                        r_short    <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_hs) begin
                        r_pack[{r_byte_cnt, 3'b000} +: 8] <= s_data;
                        r_byte_cnt <= r_byte_cnt + LP_ONE_B;
                        // s_last only counts as normal on the very last byte of the load
                        if (s_last && !(w_last_byte && w_final_word)) begin
                            r_short <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_word_cnt <= r_word_cnt + LP_ONE_W;
                    r_byte_cnt <= '0;
                    r_pack     <= '0;
                end
                ST_DONE: begin
                    r_byte_cnt <= '0;
                end
                default: begin
                    r_byte_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from state and datapath registers; idle write bus is held at zero.
    always_comb begin
        s_ready   = (r_state == ST_FILL);
        wr_en     = (r_state == ST_WRITE);
        index     = (r_state == ST_WRITE) ? r_word_cnt[IDX_W-1:0] : '0;
        data_in   = (r_state == ST_WRITE) ? r_pack : '0;
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        err_short = (r_state == ST_DONE) && r_short;
    end

endmodule

// File: tb/tb_gbuf_loader.sv
// Directed bench for gbuf_loader: packs known byte streams and checks the written rows,
// completion timing, early termination, clamping, bubbles and mid-load reset.
module tb_gbuf_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  num_words = 6'd0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        wr_en;
    logic [4:0]  index;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic        err_short;

    gbuf_loader #(.WORD_SIZE(32), .IDX_W(5), .DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .wr_en(wr_en), .index(index), .data_in(data_in), .busy(busy),
        .done(done), .err_short(err_short)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_wr_cyc = -1;
    int          min_gap = 1000;
    int          last_idx = 0;
    int          idle_bad = 0;
    int          accepted = 0;
    int          start_cyc = 0;
    logic        done_err = 1'b0;
    logic        ready_seen = 1'b0;
    logic [31:0] mem [32];
    logic [7:0]  tx [256];

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (wr_en) begin
            mem[index] = data_in;
            wr_cnt = wr_cnt + 1;
            last_idx = int'(index);
            if (last_wr_cyc >= 0 && (cyc - last_wr_cyc) < min_gap) min_gap = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
        end else if (index !== 5'd0 || data_in !== 32'd0) begin
            idle_bad = idle_bad + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            done_err = err_short;
        end
        if (s_ready) ready_seen = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr_log();
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEADBEEF;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
        min_gap = 1000; ready_seen = 1'b0; done_err = 1'b0; last_idx = 0;
    endtask

    // Drives start at step 0 then streams tx[0..nbytes-1]; returns 4 cycles after done,
    // on an abort point (reset asserted mid-cycle), or flags a timeout.
    task automatic run_load(input int num, input int nbytes, input int last_at, input int bubble,
                            input int start2_at, input int abort_at, input int max_cyc);
        int ptr = 0;
        bit pend = 1'b0;
        int tail = -1;
        accepted = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (pend) ptr++;
            if (k == 0) begin
                start = 1'b1; num_words = 6'(num); start_cyc = cyc;
            end else if (k == start2_at) begin
                start = 1'b1; num_words = 6'd1;
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && ptr == abort_at) begin
                s_valid = 1'b0; s_last = 1'b0; start = 1'b0; accepted = ptr;
                #2 rst_n = 1'b0;
                return;
            end
            if (ptr < nbytes && (bubble == 0 || (k % bubble) != 1)) begin
                s_valid = 1'b1; s_data = tx[ptr]; s_last = (ptr == last_at);
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            pend = s_valid && s_ready;
            if (tail < 0 && done_cnt > 0) tail = k;
            if (tail >= 0 && k >= tail + 4) begin
                s_valid = 1'b0; s_last = 1'b0; start = 1'b0; accepted = ptr;
                return;
            end
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0; accepted = ptr;
        vectors++; miscompares++;
        $display("FAIL timeout: no done within %0d cycles", max_cyc);
    endtask

    task automatic test_reset();
        vectors++;
        if ({s_ready, wr_en, busy, done, err_short, index, data_in} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b idx=%0d data=%h, expected all 0",
                     s_ready, wr_en, busy, done, err_short, index, data_in);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({s_ready, wr_en, busy, done, err_short} !== 5'd0) begin
            miscompares++;
            $display("FAIL idle_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b, expected all 0",
                     s_ready, wr_en, busy, done, err_short);
        end
    endtask

    task automatic test_two_words();
        for (int i = 0; i < 8; i++) tx[i] = 8'(i + 1);
        clr_log();
        run_load(2, 8, 7, 0, -1, -1, 100);
        vectors++;
        if (wr_cnt !== 2) begin miscompares++; $display("FAIL two_words_count: got %0d expected 2", wr_cnt); end
        vectors++;
        if (mem[0] !== 32'h04030201) begin miscompares++; $display("FAIL two_words_row0: got %h expected 04030201", mem[0]); end
        vectors++;
        if (mem[1] !== 32'h08070605) begin miscompares++; $display("FAIL two_words_row1: got %h expected 08070605", mem[1]); end
        vectors++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            miscompares++; $display("FAIL two_words_done: got done=%0d err=%b expected 1/0", done_cnt, done_err);
        end
        vectors++;
        if (done_cyc - start_cyc !== 11) begin
            miscompares++; $display("FAIL two_words_latency: got %0d expected 11", done_cyc - start_cyc);
        end
        vectors++;
        if (min_gap !== 5) begin miscompares++; $display("FAIL two_words_gap: got %0d expected 5", min_gap); end
    endtask

    task automatic test_short();
        for (int i = 0; i < 6; i++) tx[i] = 8'(8'hA0 + i);
        clr_log();
        run_load(3, 6, 5, 0, -1, -1, 100);
        vectors++;
        if (wr_cnt !== 2) begin miscompares++; $display("FAIL short_count: got %0d expected 2", wr_cnt); end
        vectors++;
        if (mem[0] !== 32'hA3A2A1A0) begin miscompares++; $display("FAIL short_row0: got %h expected a3a2a1a0", mem[0]); end
        vectors++;
        if (mem[1] !== 32'h0000A5A4) begin miscompares++; $display("FAIL short_row1: got %h expected 0000a5a4", mem[1]); end
        vectors++;
        if (mem[2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL short_row2: got %h expected untouched", mem[2]); end
        vectors++;
        if (done_cnt !== 1 || done_err !== 1'b1) begin
            miscompares++; $display("FAIL short_err: got done=%0d err=%b expected 1/1", done_cnt, done_err);
        end
    endtask

    task automatic test_zero();
        tx[0] = 8'h55;
        clr_log();
        run_load(0, 1, 0, 0, -1, -1, 50);
        vectors++;
        if (wr_cnt !== 0) begin miscompares++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt); end
        vectors++;
        if (done_cnt !== 1 || done_cyc - start_cyc !== 1) begin
            miscompares++; $display("FAIL zero_done: got cnt=%0d lat=%0d expected 1/1", done_cnt, done_cyc - start_cyc);
        end
        vectors++;
        if (ready_seen !== 1'b0 || accepted !== 0) begin
            miscompares++; $display("FAIL zero_ready: got ready=%b acc=%0d expected 0/0", ready_seen, accepted);
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 160; i++) tx[i] = 8'(i);
        clr_log();
        run_load(40, 160, 159, 0, -1, -1, 400);
        vectors++;
        if (wr_cnt !== 32 || last_idx !== 31) begin
            miscompares++; $display("FAIL clamp_count: got %0d writes last=%0d expected 32/31", wr_cnt, last_idx);
        end
        vectors++;
        if (accepted !== 128) begin miscompares++; $display("FAIL clamp_accepted: got %0d expected 128", accepted); end
        vectors++;
        if (mem[31] !== 32'h7F7E7D7C || mem[0] !== 32'h03020100) begin
            miscompares++; $display("FAIL clamp_rows: got r0=%h r31=%h expected 03020100/7f7e7d7c", mem[0], mem[31]);
        end
        vectors++;
        if (done_cnt !== 1 || done_err !== 1'b0 || min_gap !== 5) begin
            miscompares++; $display("FAIL clamp_done: got done=%0d err=%b gap=%0d expected 1/0/5", done_cnt, done_err, min_gap);
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 12; i++) tx[i] = 8'(8'h10 + i);
        clr_log();
        run_load(3, 12, 11, 3, 7, -1, 200);
        vectors++;
        if (wr_cnt !== 3) begin miscompares++; $display("FAIL bubble_count: got %0d expected 3", wr_cnt); end
        vectors++;
        if (mem[0] !== 32'h13121110 || mem[1] !== 32'h17161514 || mem[2] !== 32'h1B1A1918) begin
            miscompares++; $display("FAIL bubble_rows: got %h %h %h expected 13121110 17161514 1b1a1918", mem[0], mem[1], mem[2]);
        end
        vectors++;
        if (done_cnt !== 1 || done_err !== 1'b0 || min_gap < 5) begin
            miscompares++; $display("FAIL bubble_done: got done=%0d err=%b gap=%0d expected 1/0/>=5", done_cnt, done_err, min_gap);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 12; i++) tx[i] = 8'(8'h30 + i);
        clr_log();
        run_load(3, 12, 11, 0, -1, 6, 100);
        #1;
        vectors++;
        if ({s_ready, wr_en, busy, done, err_short, index, data_in} !== 42'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b idx=%0d data=%h, expected all 0",
                     s_ready, wr_en, busy, done, err_short, index, data_in);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_cnt !== 1 || mem[0] !== 32'h33323130 || done_cnt !== 0) begin
            miscompares++; $display("FAIL midreset_writes: got wr=%0d r0=%h done=%0d expected 1/33323130/0", wr_cnt, mem[0], done_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) tx[i] = 8'(8'hC0 + i);
        clr_log();
        run_load(1, 4, 3, 0, -1, -1, 50);
        vectors++;
        if (wr_cnt !== 1 || mem[0] !== 32'hC3C2C1C0 || done_cnt !== 1 || done_err !== 1'b0) begin
            miscompares++; $display("FAIL after_reset_load: got wr=%0d r0=%h done=%0d err=%b expected 1/c3c2c1c0/1/0",
                                    wr_cnt, mem[0], done_cnt, done_err);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_two_words();
        test_short();
        test_zero();
        test_clamp();
        test_bubbles();
        test_reset_mid();
        vectors++;
        if (idle_bad !== 0) begin
            miscompares++; $display("FAIL idle_bus: index/data_in nonzero without wr_en in %0d cycles, expected 0", idle_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
